seven_segment_monitor: RTL and testbench
========================================

// Module: seven_segment_monitor
// PURPOSE
//  Receive side of the 7-segment display bus: samples a common-anode seg[6:0] pattern
//  (active-low, bit0=a .. bit6=g), waits for it to be stable, then decodes it back to BCD.
//  Checks that the displayed digits follow the 0..9 count sequence with wrap.
//  Sits beside the counter/display driver as a self-check and loop-back monitor.
// PARAMETERS
//  STABLE_CYCLES  16  consecutive identical synced samples required to lock (>=2)
//  MAX_DIGIT      9   last digit before the sequence wraps to 0 (1..9)
//  CHECK_SEQ      1   1 = sequence checking enabled; 0 = seq_err held 0
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  seg_in       in   7  observed segment lines, active-low, {g,f,e,d,c,b,a}
//  digit        out  4  last accepted BCD digit
//  digit_valid  out  1  1-cycle pulse when a new digit is accepted
//  locked       out  1  current synced pattern is stable (lock reached, no change since)
//  blank        out  1  1-cycle pulse when 7'b1111111 (all off) locks
//  pattern_err  out  1  1-cycle pulse when a locked pattern is not a legal digit or blank
//  seq_err      out  1  1-cycle pulse when an accepted digit is not prev+1 (mod wrap)
//  digit_count  out  8  number of accepted digits since reset, wraps 255->0
// BEHAVIOUR
//  - Reset (sync, rst=1 at a clk edge): digit=0, digit_count=0, locked=0, all pulses=0,
//    sync regs=7'h7F, stability count=0, have_prev=0, state=WAIT.
//  - seg_in passes a 2-flop synchronizer; all logic uses the second flop (s2).
//  - Legal codes: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//    6=0000010 7=1111000 8=0000000 9=0010000. Blank=1111111. Anything else is illegal.
//  - Stability counter: width $clog2(STABLE_CYCLES+1). It clears when s2 != previous s2.
//    It increments when s2 == previous s2 and saturates at STABLE_CYCLES-1.
//  - FSM states:
//    WAIT   -> LOCKED when the counter == STABLE_CYCLES-1 and s2 is unchanged.
//              The evaluate actions below fire on exactly that edge.
//    LOCKED -> WAIT on any change of s2. locked drops on the same edge.
//    locked=1 exactly while in LOCKED.
//  - Evaluate (one cycle, on entry to LOCKED):
//    legal digit d != digit, or have_prev=0:
//      digit<=d, digit_valid=1, digit_count++, have_prev<=1.
//      If CHECK_SEQ and have_prev and d != (digit==MAX_DIGIT ? 0 : digit+1): seq_err=1.
//    legal digit d == digit with have_prev=1:
//      glitch recovery; no pulse, no count.
//    blank:
//      blank=1; digit and have_prev unchanged.
//    illegal:
//      pattern_err=1; digit unchanged.
//  - Latency: seg_in changes before edge E0 and then holds. digit_valid/blank/pattern_err
//    is high for the cycle after edge E0+1+STABLE_CYCLES (2 sync + STABLE_CYCLES-1 counts).
//  - A change shorter than the lock time never produces a pulse, and it drops locked.
//  - Pulses are mutually exclusive, except seq_err, which only coincides with digit_valid.
//  - digit_count wraps 255->0 silently. MAX_DIGIT wrap: after MAX_DIGIT, 0 is correct.
//  - rst mid-count or in LOCKED: all state returns to reset values on that edge.
//    The next lock is treated as the first digit (no seq check).
// TESTING
//  T1 reset, hold seg_in=1000000 -> one digit_valid with digit=0 at E0+1+STABLE_CYCLES,
//     seq_err=0, digit_count=1.
//  T2 step 0..9 then 0, each held 2*STABLE_CYCLES -> 11 digit_valid pulses, no seq_err,
//     digit_count=11.
//  T3 after digit 3, apply 0010010 (5) -> digit=5, digit_valid=1 and seq_err=1
//     in the same cycle.
//  T4 while locked on 4, glitch seg_in to 1111111 for STABLE_CYCLES-2 cycles and back ->
//     locked drops then relocks, no pulses, digit=4.
//  T5 hold 0101010 (illegal) -> pattern_err pulse, digit unchanged. Hold 1111111 ->
//     blank pulse only.
//  T6 assert rst for 1 cycle mid-count on digit 7, then apply 2 -> digit=2, no seq_err,
//     digit_count=1.

Source files
------------

// File: rtl/seven_segment_monitor.sv
// Loop-back monitor for a common-anode 7-segment bus: synchronizes the segment lines,
// waits for a stable pattern, decodes it to BCD and checks the 0..MAX_DIGIT count order.
module seven_segment_monitor #(
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_DIGIT     = 9,
  parameter bit CHECK_SEQ     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       locked,
  output logic       blank,
  output logic       pattern_err,
  output logic       seq_err,
  output logic [7:0] digit_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {S_WAIT, S_LOCKED} state_t;

  state_t        state, state_next;
  logic [6:0]    s1, s2;
  logic [CW-1:0] cnt;
  logic          have_prev;
  logic          changed;
  logic          fire;
  logic [3:0]    code_digit;
  logic          code_legal;
  logic          code_blank;
  logic [3:0]    succ;

  // s1 differing from s2 means s2 takes a new value on this edge, so the
  // counter clears and lock drops on the same edge that s2 changes.
  assign changed    = (s1 != s2);
  assign code_blank = (s2 == 7'h7F);
  assign succ       = (digit == 4'(MAX_DIGIT)) ? 4'd0 : digit + 4'd1;
  assign locked     = (state == S_LOCKED);

  always_comb begin
    code_digit = 4'd0;
    code_legal = 1'b1;
    case (s2)
      7'b1000000: code_digit = 4'd0;
      7'b1111001: code_digit = 4'd1;
      7'b0100100: code_digit = 4'd2;
      7'b0110000: code_digit = 4'd3;
      7'b0011001: code_digit = 4'd4;
      7'b0010010: code_digit = 4'd5;
      7'b0000010: code_digit = 4'd6;
      7'b1111000: code_digit = 4'd7;
      7'b0000000: code_digit = 4'd8;
      7'b0010000: code_digit = 4'd9;
      default:    code_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    case (state)
      S_WAIT: begin
        if (!changed && cnt == CNT_MAX) begin
          state_next = S_LOCKED;
          fire       = 1'b1;
        end
      end
      S_LOCKED: begin
        if (changed) state_next = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 7'h7F;
      s2          <= 7'h7F;
      cnt         <= '0;
      state       <= S_WAIT;
      digit       <= 4'd0;
      digit_count <= 8'd0;
      have_prev   <= 1'b0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      s1    <= seg_in;
      s2    <= s1;
      state <= state_next;
      if (changed) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      digit_valid <= 1'b0;
      blank       <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
      if (fire) begin
        if (code_blank) begin
          blank <= 1'b1;
        end else if (!code_legal) begin
          pattern_err <= 1'b1;
        end else if (!have_prev || code_digit != digit) begin
          // A relock on the digit already shown is glitch recovery, not a new digit.
          digit       <= code_digit;
          digit_valid <= 1'b1;
          digit_count <= digit_count + 8'd1;
          have_prev   <= 1'b1;
          seq_err     <= CHECK_SEQ && have_prev && (code_digit != succ);
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Bench for seven_segment_monitor: run-length reference model checked every cycle,
// a table of held patterns with hand-computed pulse counts, and targeted corner sequences.
module tb_seven_segment_monitor;

  localparam int SC   = 16;
  localparam int MAXD = 9;
  localparam int H    = 2 * SC;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] digit;
  logic       digit_valid, locked, blank, pattern_err, seq_err;
  logic [7:0] digit_count;

  always #5 clk = ~clk;

  seven_segment_monitor #(.STABLE_CYCLES(SC), .MAX_DIGIT(MAXD), .CHECK_SEQ(1'b1)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit(digit), .digit_valid(digit_valid),
    .locked(locked), .blank(blank), .pattern_err(pattern_err), .seq_err(seq_err),
    .digit_count(digit_count)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model: a pattern is evaluated once it has been sampled SC+1 times in a row.
  logic [6:0] run_val = 7'h7F;
  int run_len = 0;
  int m_digit = 0;
  bit m_have = 0;
  int m_count = 0;
  bit e_valid, e_blank, e_perr, e_seq, e_locked;

  int acc_valid, acc_seq, acc_blank, acc_perr, acc_unlock;
  bit prev_locked = 0;

  typedef struct {
    bit         do_rst;
    logic [6:0] seg;
    int         hold;
    int         exp_digit;
    int         n_valid;
    int         n_seq;
    int         n_blank;
    int         n_perr;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (codes[i] == p) return i;
    if (p == 7'h7F) return 10;
    return -1;
  endfunction

  task automatic evaluate(input logic [6:0] v);
    int d;
    d = decode(v);
    if (d == 10) e_blank = 1;
    else if (d < 0) e_perr = 1;
    else if (!m_have || d != m_digit) begin
      e_seq   = m_have && (d != ((m_digit == MAXD) ? 0 : m_digit + 1));
      m_digit = d;
      m_have  = 1;
      m_count = (m_count + 1) % 256;
      e_valid = 1;
    end
  endtask

  task automatic model_edge(input logic [6:0] x, input bit r);
    e_valid = 0; e_blank = 0; e_perr = 0; e_seq = 0;
    if (r) begin
      run_val = 7'h7F; run_len = 2;
      m_digit = 0; m_have = 0; m_count = 0; e_locked = 0;
    end else begin
      if (run_len == SC + 1) evaluate(run_val);
      e_locked = (run_len >= SC + 1);
      if (x == run_val) run_len++;
      else begin run_val = x; run_len = 1; end
    end
  endtask

  task automatic step(input logic [6:0] x);
    logic [16:0] act, exp;
    seg_in = x;
    @(posedge clk);
    model_edge(x, rst);
    #1;
    act = {digit, digit_valid, locked, blank, pattern_err, seq_err, digit_count};
    exp = {4'(m_digit), e_valid, e_locked, e_blank, e_perr, e_seq, 8'(m_count)};
    check("cycle", 32'(act), 32'(exp));
    acc_valid  += int'(digit_valid);
    acc_seq    += int'(seq_err);
    acc_blank  += int'(blank);
    acc_perr   += int'(pattern_err);
    acc_unlock += int'(prev_locked && !locked);
    prev_locked = locked;
  endtask

  task automatic clear_acc();
    acc_valid = 0; acc_seq = 0; acc_blank = 0; acc_perr = 0; acc_unlock = 0;
  endtask

  task automatic do_reset(input logic [6:0] x);
    rst = 1'b1;
    step(x);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input bit r, input logic [6:0] s, input int h, input int d,
                              input int nv, input int ns, input int nb, input int np);
    vec_t v;
    v.do_rst = r; v.seg = s; v.hold = h; v.exp_digit = d;
    v.n_valid = nv; v.n_seq = ns; v.n_blank = nb; v.n_perr = np;
    return v;
  endfunction

  initial begin
    int first_idx;
    int d;
    int r;
    logic [6:0] pat;

    // Count sequence 0..9,0 then a skip, blank, illegal and same-digit relock.
    for (int i = 0; i <= 10; i++)
      vecs.push_back(mk(i == 0, codes[i % 10], H, i % 10, 1, 0, 0, 0));
    vecs.push_back(mk(1, codes[0], H, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, codes[1], H, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, codes[2], H, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, codes[3], H, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, codes[5], H, 5, 1, 1, 0, 0));
    vecs.push_back(mk(0, codes[6], H, 6, 1, 0, 0, 0));
    vecs.push_back(mk(0, 7'b0101010, H, 6, 0, 0, 0, 1));
    vecs.push_back(mk(0, 7'h7F, H, 6, 0, 0, 1, 0));
    vecs.push_back(mk(0, codes[6], H, 6, 0, 0, 0, 0));
    vecs.push_back(mk(0, codes[7], SC, 6, 0, 0, 0, 0));
    vecs.push_back(mk(0, codes[7], H, 7, 1, 0, 0, 0));

    // T1: first lock latency after reset.
    do_reset(codes[0]);
    clear_acc();
    first_idx = -1;
    for (int i = 1; i <= 3 * SC; i++) begin
      step(codes[0]);
      if (digit_valid && first_idx < 0) first_idx = i;
    end
    check("t1_latency", 32'(first_idx), 32'(SC + 2));
    check("t1_count", 32'(digit_count), 32'd1);
    check("t1_seq", 32'(acc_seq), 32'd0);

    // Table of held patterns.
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].do_rst) do_reset(vecs[v].seg);
      clear_acc();
      repeat (vecs[v].hold) step(vecs[v].seg);
      check($sformatf("vec%0d_digit", v), 32'(digit), 32'(vecs[v].exp_digit));
      check($sformatf("vec%0d_valid", v), 32'(acc_valid), 32'(vecs[v].n_valid));
      check($sformatf("vec%0d_seq", v), 32'(acc_seq), 32'(vecs[v].n_seq));
      check($sformatf("vec%0d_blank", v), 32'(acc_blank), 32'(vecs[v].n_blank));
      check($sformatf("vec%0d_perr", v), 32'(acc_perr), 32'(vecs[v].n_perr));
      if (v == 10) check("t2_count", 32'(digit_count), 32'd11);
    end

    // T4: short blank glitch while locked on 4.
    do_reset(codes[3]);
    repeat (H) step(codes[3]);
    repeat (H) step(codes[4]);
    clear_acc();
    repeat (SC - 2) step(7'h7F);
    repeat (H) step(codes[4]);
    check("t4_unlock", 32'(acc_unlock), 32'd1);
    check("t4_pulses", 32'(acc_valid + acc_blank + acc_perr + acc_seq), 32'd0);
    check("t4_digit", 32'(digit), 32'd4);
    check("t4_locked", 32'(locked), 32'd1);

    // T6: reset mid-count on 7, then 2 is a first digit.
    do_reset(codes[6]);
    repeat (H) step(codes[6]);
    repeat (SC / 2) step(codes[7]);
    do_reset(codes[7]);
    clear_acc();
    repeat (H) step(codes[2]);
    check("t6_digit", 32'(digit), 32'd2);
    check("t6_seq", 32'(acc_seq), 32'd0);
    check("t6_count", 32'(digit_count), 32'd1);

    // digit_count wrap past 255.
    do_reset(codes[0]);
    for (int i = 0; i < 260; i++) repeat (SC + 2) step(codes[i % 10]);
    check("wrap_count", 32'(digit_count), 32'd4);

    // Randomized segments against the model.
    do_reset(7'h7F);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : (m_digit + 1) % 10;
        pat = codes[d];
      end else if (r < 7) begin
        pat = 7'h7F;
      end else begin
        pat = 7'($urandom);
      end
      repeat ($urandom_range(1, 2 * SC + 4)) step(pat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
